// File: rtl/vga_buf_reader_if.sv
// Display-side port bundle of the vga_buf frame store: bank handshake, read port and DAC outputs.
// The reader drives the master modport; the frame store/DAC/writer side uses slave.
interface vga_buf_reader_if;
    logic        wr_frame_done;
    logic        front_bank;
    logic        swap_ack;
    logic [17:0] buf_rd_addr;
    logic [11:0] buf_rd_data;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [11:0] rgb;

    modport master (
        input  wr_frame_done,
        input  buf_rd_data,
        output front_bank,
        output swap_ack,
        output buf_rd_addr,
        output hsync,
        output vsync,
        output blank,
        output rgb
    );

    modport slave (
        output wr_frame_done,
        output buf_rd_data,
        input  front_bank,
        input  swap_ack,
        input  buf_rd_addr,
        input  hsync,
        input  vsync,
        input  blank,
        input  rgb
    );
endinterface

// File: rtl/vga_buf_reader.sv
// VGA timing generator and front-bank reader of the 320x240 double-banked frame store.
// One stored pixel covers a 2x2 screen block; syncs/blank are delayed to line up with rgb.
module vga_buf_reader #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned RD_LAT   = 2,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    vga_buf_reader_if.master  bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DLEN    = RD_LAT + 2;

    localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HActEnd = 10'(H_ACTIVE);
    localparam logic [9:0] VActEnd = 10'(V_ACTIVE);
    localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]      hcount_q, hcount_d;
    logic [9:0]      vcount_q, vcount_d;
    logic            act, hs, vs;
    logic [8:0]      x;
    logic [7:0]      y;
    logic [16:0]     addr_q, addr_d;
    logic            swap;
    logic            swap_pend_q, swap_pend_d;
    logic            front_bank_q;
    logic [DLEN-1:0] act_dly_q, hs_dly_q, vs_dly_q;
    logic [11:0]     rgb_q;

    always_comb begin
        hcount_d = (hcount_q == HLast) ? 10'd0 : hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == HLast) begin
            vcount_d = (vcount_q == VLast) ? 10'd0 : vcount_q + 10'd1;
        end

        act = (hcount_q < HActEnd) && (vcount_q < VActEnd);
        hs  = (hcount_q >= HsStart) && (hcount_q < HsEnd);
        vs  = (vcount_q >= VsStart) && (vcount_q < VsEnd);

        // y*320 + x as two shifts and adds; y only matters inside the active area.
        x      = hcount_q[9:1];
        y      = vcount_q[8:1];
        addr_d = act ? (17'(y) << 8) + (17'(y) << 6) + 17'(x) : 17'd0;

        // Swap point sits in vertical blanking, so the displayed bank never changes mid-picture.
        swap        = swap_pend_q && (hcount_q == 10'd0) && (vcount_q == VActEnd);
        swap_pend_d = bus.wr_frame_done | (swap_pend_q & ~swap);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q     <= '0;
            vcount_q     <= '0;
            addr_q       <= '0;
            swap_pend_q  <= 1'b0;
            front_bank_q <= 1'b0;
            act_dly_q    <= '0;
            hs_dly_q     <= '0;
            vs_dly_q     <= '0;
            rgb_q        <= '0;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            addr_q       <= addr_d;
            swap_pend_q  <= swap_pend_d;
            front_bank_q <= front_bank_q ^ swap;
            act_dly_q    <= {act_dly_q[DLEN-2:0], act};
            hs_dly_q     <= {hs_dly_q[DLEN-2:0], hs};
            vs_dly_q     <= {vs_dly_q[DLEN-2:0], vs};
            // Stage RD_LAT is aligned with buf_rd_data for the same pixel.
            rgb_q        <= act_dly_q[RD_LAT] ? bus.buf_rd_data : 12'd0;
        end
    end

    always_comb begin
        bus.front_bank  = front_bank_q;
        bus.swap_ack    = swap & ~reset;
        bus.buf_rd_addr = {front_bank_q, addr_q};
        bus.blank       = ~act_dly_q[DLEN-1];
        bus.hsync       = hs_dly_q[DLEN-1] ? SYNC_POL : ~SYNC_POL;
        bus.vsync       = vs_dly_q[DLEN-1] ? SYNC_POL : ~SYNC_POL;
        bus.rgb         = rgb_q;
    end
endmodule

// File: tb/tb_vga_buf_reader.sv
// Bench for vga_buf_reader on a reduced 24x12 raster (16x8 active) so several frames fit in a short run.
// Read model returns addr[11:0] two cycles after the address.
module tb_vga_buf_reader;
    localparam int HT = 24;
    localparam int VT = 12;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic reset;
    logic [17:0] rd_pipe0, rd_pipe1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int hs_low = 0;
    int vs_low = 0;
    int blank_err = 0;
    int max_addr = 0;

    vga_buf_reader_if bus();

    vga_buf_reader #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .RD_LAT(2),    .SYNC_POL(1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_pipe0 <= bus.buf_rd_addr;
        rd_pipe1 <= rd_pipe0;
        cyc      <= reset ? 0 : cyc + 1;
    end
    assign bus.buf_rd_data = rd_pipe1[11:0];

    function automatic bit exp_blank_at(input int n);
        int p;
        p = n - 4;
        return !(((p % HT) < 16) && (((p / HT) % VT) < 8));
    endfunction

    // Two-frame scan of the output stream: cycle n shows screen position n-4.
    always @(negedge clk) begin
        if (bus.swap_ack) ack_cnt <= ack_cnt + 1;
        if (!reset && cyc >= 4 && cyc < 4 + 2 * FR) begin
            if (bus.blank !== exp_blank_at(cyc) || (bus.blank && bus.rgb !== 12'd0))
                blank_err <= blank_err + 1;
            if (!bus.hsync) hs_low <= hs_low + 1;
            if (!bus.vsync) vs_low <= vs_low + 1;
            if (int'(bus.buf_rd_addr[16:0]) > max_addr) max_addr <= int'(bus.buf_rd_addr[16:0]);
        end
    end

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cyc %0d",
                     name, act_v, act_v, exp_v, exp_v, cyc);
        end
    endtask

    task automatic at_cyc(input int n);
        int k;
        k = 0;
        while (cyc != n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (cyc != n) begin
            $display("FAIL timeout waiting for cyc %0d", n);
            failures++;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "timeout");
        end
    endtask

    task automatic pulse_done(input int n);
        at_cyc(n);
        bus.wr_frame_done = 1'b1;
        @(negedge clk);
        bus.wr_frame_done = 1'b0;
    endtask

    typedef struct {
        int h;
        int v;
        logic blank;
        logic hsync;
        logic vsync;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs[17];

    task automatic chk_reset_state(input string tag);
        chk({tag, "_front_bank"}, int'(bus.front_bank), 0);
        chk({tag, "_swap_ack"}, int'(bus.swap_ack), 0);
        chk({tag, "_addr"}, int'(bus.buf_rd_addr), 0);
        chk({tag, "_blank"}, int'(bus.blank), 1);
        chk({tag, "_rgb"}, int'(bus.rgb), 0);
        chk({tag, "_hsync"}, int'(bus.hsync), 1);
        chk({tag, "_vsync"}, int'(bus.vsync), 1);
    endtask

    initial begin
        // Output-side expectations in frame 0 (h, v, blank, hsync, vsync, rgb = addr[11:0]).
        vecs[0]  = '{0, 0, 1'b0, 1'b1, 1'b1, 12'h000};
        vecs[1]  = '{2, 0, 1'b0, 1'b1, 1'b1, 12'h001};
        vecs[2]  = '{3, 0, 1'b0, 1'b1, 1'b1, 12'h001};
        vecs[3]  = '{15, 0, 1'b0, 1'b1, 1'b1, 12'h007};
        vecs[4]  = '{16, 0, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[5]  = '{17, 0, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[6]  = '{18, 0, 1'b1, 1'b0, 1'b1, 12'h000};
        vecs[7]  = '{21, 0, 1'b1, 1'b0, 1'b1, 12'h000};
        vecs[8]  = '{22, 0, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[9]  = '{0, 1, 1'b0, 1'b1, 1'b1, 12'h000};
        vecs[10] = '{4, 2, 1'b0, 1'b1, 1'b1, 12'h142};
        vecs[11] = '{15, 7, 1'b0, 1'b1, 1'b1, 12'h3C7};
        vecs[12] = '{0, 8, 1'b1, 1'b1, 1'b1, 12'h000};
        vecs[13] = '{0, 9, 1'b1, 1'b1, 1'b0, 12'h000};
        vecs[14] = '{18, 9, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[15] = '{23, 10, 1'b1, 1'b1, 1'b0, 12'h000};
        vecs[16] = '{0, 11, 1'b1, 1'b1, 1'b1, 12'h000};

        reset = 1'b1;
        bus.wr_frame_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_reset_state("init");

        for (int i = 0; i < 17; i++) begin
            at_cyc(vecs[i].h + HT * vecs[i].v + 4);
            chk($sformatf("vec%0d_blank", i), int'(bus.blank), int'(vecs[i].blank));
            chk($sformatf("vec%0d_hsync", i), int'(bus.hsync), int'(vecs[i].hsync));
            chk($sformatf("vec%0d_vsync", i), int'(bus.vsync), int'(vecs[i].vsync));
            chk($sformatf("vec%0d_rgb", i), int'(bus.rgb), int'(vecs[i].rgb));
        end

        // Frame 1: address lands one cycle after the counters.
        at_cyc(FR + 5 + HT * 3 + 1);
        chk("addr_5_3", int'(bus.buf_rd_addr), 322);
        at_cyc(FR + 15 + HT * 7 + 1);
        chk("addr_last_px", int'(bus.buf_rd_addr), 967);
        at_cyc(FR + 16 + HT * 7 + 1);
        chk("addr_after_active", int'(bus.buf_rd_addr), 0);

        at_cyc(4 + 2 * FR);
        chk("hsync_low_2fr", hs_low, 2 * VT * 4);
        chk("vsync_low_2fr", vs_low, 2 * HT * 2);
        chk("blank_rgb_errs", blank_err, 0);
        chk("max_addr", max_addr, 967);
        chk("no_ack_yet", ack_cnt, 0);

        // Two writer pulses in frame 2 collapse into one swap at (0,8).
        pulse_done(2 * FR + 5 + HT * 2);
        pulse_done(2 * FR + 10 + HT * 2);
        at_cyc(2 * FR + HT * 8 - 1);
        chk("t4_no_early_ack", int'(bus.swap_ack), 0);
        at_cyc(2 * FR + HT * 8);
        chk("t4_ack", int'(bus.swap_ack), 1);
        chk("t4_bank_before", int'(bus.front_bank), 0);
        at_cyc(2 * FR + HT * 8 + 1);
        chk("t4_bank_after", int'(bus.front_bank), 1);
        chk("t4_addr_bank", int'(bus.buf_rd_addr[17]), 1);
        chk("t4_ack_pulse", int'(bus.swap_ack), 0);
        at_cyc(4 * FR - 1);
        chk("t4_single_ack", ack_cnt, 1);

        // Pending swap plus a new pulse exactly on the swap point.
        pulse_done(4 * FR + 3 + HT * 3);
        at_cyc(4 * FR + HT * 8);
        bus.wr_frame_done = 1'b1;
        chk("t5_ack", int'(bus.swap_ack), 1);
        @(negedge clk);
        bus.wr_frame_done = 1'b0;
        chk("t5_bank", int'(bus.front_bank), 0);
        at_cyc(5 * FR + HT * 8);
        chk("t5_ack_next", int'(bus.swap_ack), 1);
        at_cyc(5 * FR + HT * 8 + 1);
        chk("t5_bank_next", int'(bus.front_bank), 1);
        chk("t5_ack_cnt", ack_cnt, 3);

        // Mid-frame reset with a swap pending.
        pulse_done(6 * FR + 30);
        at_cyc(6 * FR + 8 + HT * 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state("t6");
        at_cyc(3);
        chk("t6_addr_restart", int'(bus.buf_rd_addr), 1);
        at_cyc(4);
        chk("t6_first_active", int'(bus.blank), 0);
        at_cyc(HT * 8 + 8);
        chk("t6_pend_cleared", ack_cnt, 3);
        chk("t6_bank_held", int'(bus.front_bank), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
